// File: rtl/fetch_pkg.sv
// Types and defaults for the instruction-fetch request controller.
package fetch_pkg;
  localparam int unsigned FETCH_MAX_OUTSTANDING = 4;

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_EXCEPT = 2'd2
  } fetch_ctrl_state_t;
endpackage

// File: rtl/len5_pkg.sv
// Core-wide datapath widths shared by the front-end blocks.
package len5_pkg;
  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;
endpackage

// File: rtl/fetch_pc_fifo.sv
// PC FIFO for live fetch requests; clear beats push, push+pop legal when full.
module fetch_pc_fifo
  import len5_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            push_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            pop_i,
  output logic [XLEN-1:0] head_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            do_push;

  assign do_push = push_i & ~clear_i;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= pc_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_req_ctrl.sv
// Instruction-fetch request sequencer: issues PCs to memory, tracks in-flight
// requests, drops stale responses after redirects and pairs responses with PCs.
module fetch_req_ctrl
  import len5_pkg::*;
  import fetch_pkg::*;
#(
  parameter  int unsigned MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING,
  localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pc_valid_i,
  input  logic [XLEN-1:0]  pc_i,
  output logic             pc_advance_o,
  input  logic             flush_i,
  output logic             mem_req_valid_o,
  input  logic             mem_req_ready_i,
  output logic [XLEN-1:0]  mem_req_addr_o,
  input  logic             mem_rsp_valid_i,
  output logic             mem_rsp_ready_o,
  input  logic [ILEN-1:0]  mem_rsp_instr_i,
  input  logic             mem_rsp_except_i,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic [ILEN-1:0]  instr_o,
  output logic [XLEN-1:0]  instr_pc_o,
  output logic             instr_except_o,
  output logic [CNT_W-1:0] inflight_o
);

  localparam int unsigned SUM_W = CNT_W + 1;

  fetch_ctrl_state_t state_q, state_d;
  logic [CNT_W-1:0]  live_q, live_d, drop_q, drop_d;
  logic [SUM_W-1:0]  total;
  logic              flush_act, deliver, rsp_ready_int, slot_free;
  logic              rsp_hs, instr_hs, exc_hs, req_hs;
  logic              fifo_clear, fifo_push, fifo_full, fifo_empty;

  assign total     = SUM_W'(live_q) + SUM_W'(drop_q);
  assign flush_act = flush_i & (state_q != S_BOOT);

  // Responses reach the fetch buffer only when nothing stale is ahead of them
  assign deliver       = ~flush_act & (drop_q == '0) & ~fifo_empty;
  assign rsp_ready_int = deliver ? instr_ready_i : 1'b1;
  assign rsp_hs        = mem_rsp_valid_i & rsp_ready_int;
  assign instr_hs      = deliver & mem_rsp_valid_i & instr_ready_i;
  assign exc_hs        = instr_hs & mem_rsp_except_i;
  assign req_hs        = pc_advance_o;

  // A response retiring this cycle frees its slot for a same-cycle request
  assign slot_free = (total < SUM_W'(MAX_OUTSTANDING)) | (rsp_hs & (total != '0));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_BOOT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_RUN;
      default: begin
        if (flush_act)   state_d = S_RUN;
        else if (exc_hs) state_d = S_EXCEPT;
      end
    endcase
  end

  always_comb begin
    mem_req_valid_o = 1'b0;
    pc_advance_o    = 1'b0;
    mem_rsp_ready_o = rsp_ready_int;
    instr_valid_o   = deliver & mem_rsp_valid_i;
    if ((state_q == S_RUN) && pc_valid_i && !flush_i && slot_free) mem_req_valid_o = 1'b1;
    pc_advance_o = mem_req_valid_o & mem_req_ready_i;
  end

  // Redirects and fetch faults turn every live request into a pending drop
  always_comb begin
    live_d = live_q;
    drop_d = drop_q;
    if (flush_act) begin
      live_d = '0;
      drop_d = drop_q + live_q - CNT_W'(rsp_hs & (total != '0));
    end else if (exc_hs) begin
      live_d = '0;
      drop_d = drop_q + live_q - CNT_W'(1) + CNT_W'(req_hs);
    end else begin
      live_d = live_q + CNT_W'(req_hs) - CNT_W'(instr_hs);
      if (rsp_hs && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      live_q <= '0;
      drop_q <= '0;
    end else begin
      live_q <= live_d;
      drop_q <= drop_d;
    end
  end

  assign fifo_clear = flush_act | exc_hs;
  assign fifo_push  = req_hs & (~fifo_full | instr_hs);

  fetch_pc_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (fifo_clear),
    .push_i  (fifo_push),
    .pc_i    (pc_i),
    .pop_i   (instr_hs),
    .head_o  (instr_pc_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign mem_req_addr_o = pc_i;
  assign instr_o        = mem_rsp_instr_i;
  assign instr_except_o = mem_rsp_except_i;
  assign inflight_o     = CNT_W'(total);

  a_orphan_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rsp_valid_i |-> (total != '0));
  a_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    total <= SUM_W'(MAX_OUTSTANDING));
  a_live_fifo: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (live_q == '0) == fifo_empty);
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req_hs & fifo_full & ~fifo_clear) |-> instr_hs);

endmodule

// File: tb/tb_fetch_req_ctrl.sv
// Bench for fetch_req_ctrl: directed scenarios then random traffic, checked
// against a queue-based model of the fetch rules and an in-order memory.
module tb_fetch_req_ctrl;
  import len5_pkg::*;

  localparam int unsigned MAXO = 4;
  localparam int unsigned CW   = $clog2(MAXO + 1);

  logic            clk_i, rst_ni;
  logic            pc_valid_i, pc_advance_o, flush_i;
  logic [XLEN-1:0] pc_i, mem_req_addr_o, instr_pc_o;
  logic            mem_req_valid_o, mem_req_ready_i;
  logic            mem_rsp_valid_i, mem_rsp_ready_o, mem_rsp_except_i;
  logic [ILEN-1:0] mem_rsp_instr_i, instr_o;
  logic            instr_valid_o, instr_ready_i, instr_except_o;
  logic [CW-1:0]   inflight_o;

  fetch_req_ctrl #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .pc_valid_i(pc_valid_i), .pc_i(pc_i), .pc_advance_o(pc_advance_o),
    .flush_i(flush_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
    .mem_rsp_instr_i(mem_rsp_instr_i), .mem_rsp_except_i(mem_rsp_except_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_except_o(instr_except_o),
    .inflight_o(inflight_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
    int          due;
  } mrsp_t;

  mrsp_t       mq[$];
  logic [31:0] exp_q[$];
  int          drop_m, mode_m;  // mode: 0 boot, 1 run, 2 except
  int          cyc, errors, checks;

  logic        pcv, rq_rdy, in_rdy, withhold, flush_k, rsp_v;
  logic [31:0] pc_cur, flush_tgt, exc_on_pc;
  int          lat;
  bit          rnd_exc, rnd_lat;

  bit          e_rready, e_ivalid, e_req, e_adv, rsp_hs_m, fl_m;
  int          total_m;

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    pc_valid_i      = pcv;
    pc_i            = pc_cur;
    mem_req_ready_i = rq_rdy;
    instr_ready_i   = in_rdy;
    flush_i         = flush_k;
    if (mq.size() > 0 && !withhold && cyc >= mq[0].due) begin
      rsp_v            = 1'b1;
      mem_rsp_instr_i  = mq[0].instr;
      mem_rsp_except_i = mq[0].exc;
    end else begin
      rsp_v            = 1'b0;
      mem_rsp_instr_i  = $urandom;
      mem_rsp_except_i = 1'($urandom_range(0, 1));
    end
    mem_rsp_valid_i = rsp_v;
    #1;
  endtask

  task automatic check_model();
    fl_m    = flush_k && (mode_m != 0);
    total_m = exp_q.size() + drop_m;
    if (fl_m || drop_m > 0 || total_m == 0) begin
      e_rready = 1'b1;
      e_ivalid = 1'b0;
    end else begin
      e_rready = in_rdy;
      e_ivalid = rsp_v;
    end
    rsp_hs_m = rsp_v && e_rready;
    e_req = pcv && (mode_m == 1) && !flush_k &&
            (total_m < MAXO || (rsp_hs_m && total_m > 0));
    e_adv = e_req && rq_rdy;
    chk("req_valid", 32'(mem_req_valid_o), 32'(e_req));
    chk("pc_advance", 32'(pc_advance_o), 32'(e_adv));
    if (e_req) chk("req_addr", mem_req_addr_o, pc_cur);
    chk("rsp_ready", 32'(mem_rsp_ready_o), 32'(e_rready));
    chk("instr_valid", 32'(instr_valid_o), 32'(e_ivalid));
    chk("inflight", 32'(inflight_o), 32'(total_m));
    if (e_ivalid) begin
      chk("instr_pc", instr_pc_o, exp_q[0]);
      chk("instr", instr_o, mq[0].instr);
      chk("instr_except", 32'(instr_except_o), 32'(mq[0].exc));
    end
  endtask

  task automatic tick();
    bit   ihs, exc_now, exc_pick;
    int   lat_pick;
    ihs     = e_ivalid && in_rdy;
    exc_now = ihs ? mq[0].exc : 1'b0;
    @(posedge clk_i);
    if (rsp_hs_m) void'(mq.pop_front());
    if (mode_m == 0) mode_m = 1;
    else if (fl_m) begin
      drop_m = drop_m + exp_q.size() - ((rsp_hs_m && total_m > 0) ? 1 : 0);
      exp_q.delete();
      mode_m = 1;
    end else if (ihs && exc_now) begin
      drop_m = drop_m + exp_q.size() - 1 + (e_adv ? 1 : 0);
      exp_q.delete();
      mode_m = 2;
    end else begin
      if (ihs) void'(exp_q.pop_front());
      else if (rsp_hs_m && drop_m > 0) drop_m--;
      if (e_adv) exp_q.push_back(pc_cur);
    end
    if (e_adv) begin
      exc_pick = (pc_cur == exc_on_pc) || (rnd_exc && $urandom_range(0, 15) == 0);
      lat_pick = rnd_lat ? int'($urandom_range(0, 3)) : lat;
      mq.push_back('{pc: pc_cur, instr: instr_of(pc_cur), exc: exc_pick, due: cyc + lat_pick});
    end
    if (flush_k)    pc_cur = flush_tgt;
    else if (e_adv) pc_cur = pc_cur + 32'd4;
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic step();
    drive();
    check_model();
    tick();
  endtask

  task automatic drain();
    pcv = 1'b0; withhold = 1'b0; flush_k = 1'b0; in_rdy = 1'b1;
    for (int i = 0; i < 60 && (mq.size() > 0 || exp_q.size() + drop_m > 0); i++) step();
    drive();
    check_model();
    chk("drain_inflight", 32'(inflight_o), 32'd0);
    tick();
  endtask

  initial begin
    bit seen;
    errors = 0; checks = 0; cyc = 0;
    drop_m = 0; mode_m = 0;
    pcv = 1'b1; rq_rdy = 1'b1; in_rdy = 1'b1; withhold = 1'b0; flush_k = 1'b0;
    pc_cur = 32'h0; flush_tgt = 32'h0; exc_on_pc = 32'hFFFF_FFFF;
    lat = 2; rnd_exc = 0; rnd_lat = 0;

    // Reset state
    rst_ni = 1'b0;
    drive();
    #1;
    chk("rst_req_valid", 32'(mem_req_valid_o), 32'd0);
    chk("rst_pc_advance", 32'(pc_advance_o), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_inflight", 32'(inflight_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Boot: no request in the first cycle, then PC 0x0 issues
    drive(); check_model();
    chk("boot_noreq", 32'(mem_req_valid_o), 32'd0);
    tick();
    drive(); check_model();
    chk("boot_req", 32'(mem_req_valid_o), 32'd1);
    chk("boot_addr", mem_req_addr_o, 32'h0);
    chk("boot_adv", 32'(pc_advance_o), 32'd1);
    tick();

    // Streaming with two-cycle memory latency
    for (int i = 0; i < 10; i++) begin
      drive(); check_model();
      chk("stream_inflight_le2", 32'(inflight_o > CW'(2)), 32'd0);
      tick();
    end
    drain();

    // Full: memory withholds, then one response lets a request through
    withhold = 1'b1; pcv = 1'b1; lat = 0;
    for (int i = 0; i < 6; i++) step();
    drive(); check_model();
    chk("full_inflight", 32'(inflight_o), 32'd4);
    chk("full_noreq", 32'(mem_req_valid_o), 32'd0);
    chk("full_noadv", 32'(pc_advance_o), 32'd0);
    tick();
    withhold = 1'b0;
    drive(); check_model();
    chk("full_reissue", 32'(mem_req_valid_o), 32'd1);
    chk("full_reissue_adv", 32'(pc_advance_o), 32'd1);
    tick();
    drain();

    // Flush with three live and one response in the same cycle
    withhold = 1'b1; pcv = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() < 3; i++) step();
    pcv = 1'b0; withhold = 1'b0; flush_k = 1'b1; flush_tgt = 32'h100;
    drive(); check_model();
    chk("flush_rsp_ready", 32'(mem_rsp_ready_o), 32'd1);
    chk("flush_no_instr", 32'(instr_valid_o), 32'd0);
    tick();
    flush_k = 1'b0; pcv = 1'b1;
    drive(); check_model();
    chk("flush_drop2", 32'(inflight_o), 32'd2);
    tick();
    pcv = 1'b0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      drive(); check_model();
      if (instr_valid_o) begin
        chk("flush_redirect_pc", instr_pc_o, 32'h100);
        seen = 1;
      end
      tick();
    end
    chk("flush_redirect_seen", 32'(seen), 32'd1);
    drain();

    // Exception on the second of three live responses
    lat = 1; withhold = 1'b1; pcv = 1'b1; pc_cur = 32'h200; exc_on_pc = 32'h204;
    for (int i = 0; i < 10 && exp_q.size() < 3; i++) step();
    pcv = 1'b0; withhold = 1'b0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      drive(); check_model();
      if (instr_valid_o && instr_except_o) begin
        chk("exc_pc", instr_pc_o, 32'h204);
        seen = 1;
      end
      tick();
    end
    chk("exc_seen", 32'(seen), 32'd1);
    pcv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(); check_model();
      chk("exc_noreq", 32'(mem_req_valid_o), 32'd0);
      tick();
    end
    flush_k = 1'b1; flush_tgt = 32'h300;
    step();
    flush_k = 1'b0;
    drive(); check_model();
    chk("resume_req", 32'(mem_req_valid_o), 32'd1);
    chk("resume_addr", mem_req_addr_o, 32'h300);
    tick();
    exc_on_pc = 32'hFFFF_FFFF;
    drain();

    // Backpressure: held while delivering, ignored while dropping
    lat = 0; pcv = 1'b1; pc_cur = 32'h400; withhold = 1'b1;
    step();
    pcv = 1'b0; withhold = 1'b0; in_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(); check_model();
      chk("bp_rsp_ready0", 32'(mem_rsp_ready_o), 32'd0);
      chk("bp_head_held", instr_pc_o, 32'h400);
      tick();
    end
    withhold = 1'b1; flush_k = 1'b1; flush_tgt = 32'h500;
    step();
    flush_k = 1'b0; withhold = 1'b0;
    drive(); check_model();
    chk("bp_drop_ready", 32'(mem_rsp_ready_o), 32'd1);
    tick();
    drain();

    // Random traffic
    rnd_exc = 1; rnd_lat = 1;
    for (int i = 0; i < 2500; i++) begin
      pcv       = ($urandom_range(0, 3) != 0);
      rq_rdy    = ($urandom_range(0, 3) != 0);
      in_rdy    = ($urandom_range(0, 3) != 0);
      withhold  = ($urandom_range(0, 4) == 0);
      flush_k   = ($urandom_range(0, 11) == 0);
      flush_tgt = $urandom & 32'hFFFF_FFFC;
      step();
    end
    rnd_exc = 0; rnd_lat = 0; lat = 1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
